seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display_if.sv | 25 ++
 rtl/seg_scan_display.sv | 218 +++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// Bus bundle for the multiplexed 7-segment scanner: display data and
// control in, digit/segment drives and status strobes out.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    EN;
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] Data;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    Blank_LZ;
  logic [NUM_DIGITS-1:0]   COM;
  logic [7:0]              SEG;
  logic                    Load_Ack;
  logic                    Frame_Tick;

  modport master (
    output EN, Load, Data, DP, Blank_LZ,
    input  COM, SEG, Load_Ack, Frame_Tick
  );

  modport slave (
    input  EN, Load, Data, DP, Blank_LZ,
    output COM, SEG, Load_Ack, Frame_Tick
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed hex 7-segment scanner with shadow/active double buffering,
// anti-ghost dead time between digits and leading-zero blanking.
//
// state | meaning
// IDLE  | display dark, index and divider cleared, waits for EN
// SCAN  | current digit lit for DIV cycles
// DEAD  | all drivers off for DEAD_CYCLES cycles before the next digit
module seg_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic               Sys_CLK,
  input logic               Sys_RST,
  seg_scan_display_if.slave bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic [DW-1:0]           div_q;
  logic [DW-1:0]           dead_q;
  logic [4*NUM_DIGITS-1:0] sh_data, act_data;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic                    sh_blz, act_blz;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   com_q;
  logic [7:0]              seg_q;
  logic                    load_ack_q;
  logic                    frame_tick_q;

  logic                    last_lit;
  logic                    frame_end;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] nx_data;
  logic [NUM_DIGITS-1:0]   nx_dp;
  logic                    nx_blz;
  logic [IW-1:0]           idx_nx;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [7:0]              seg_first, seg_next;
  logic [NUM_DIGITS-1:0]   com_first, com_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] com_sel(input logic [IW-1:0] k);
    logic [NUM_DIGITS-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    return COM_ACTIVE_LOW ? ~oh : oh;
  endfunction

  assign last_lit  = (div_q == DIV_LAST);
  assign frame_end = bus.EN && (state_q == SCAN) && last_lit && (idx_q == IDX_LAST);
  assign commit    = pending_q && ((bus.EN && (state_q == IDLE)) || frame_end);
  assign idx_nx    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // A digit lit on the same edge as a commit must already show the new bank.
  assign nx_data = commit ? sh_data : act_data;
  assign nx_dp   = commit ? sh_dp   : act_dp;
  assign nx_blz  = commit ? sh_blz  : act_blz;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = nx_data[4*i +: 4];
    end
  end

  // Blank from the top digit down until the first nonzero nibble; digit 0 stays.
  always_comb begin
    zero_run = nx_blz;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (nib[i] != 4'h0) zero_run = 1'b0;
      blank[i] = zero_run;
    end
  end

  always_comb begin
    seg_first = {nx_dp[0], hex7(nib[0])};
    seg_next  = {nx_dp[idx_nx], blank[idx_nx] ? 7'h00 : hex7(nib[idx_nx])};
    if (SEG_ACTIVE_LOW) begin
      seg_first = ~seg_first;
      seg_next  = ~seg_next;
    end
    com_first = com_sel('0);
    com_next  = com_sel(idx_nx);
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      div_q        <= '0;
      dead_q       <= '0;
      sh_data      <= '0;
      sh_dp        <= '0;
      sh_blz       <= 1'b0;
      act_data     <= '0;
      act_dp       <= '0;
      act_blz      <= 1'b0;
      pending_q    <= 1'b0;
      com_q        <= COM_OFF;
      seg_q        <= SEG_OFF;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      load_ack_q   <= commit;
      frame_tick_q <= frame_end;

      if (commit) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
        act_blz  <= sh_blz;
      end

      // A Load on the commit edge keeps pending so its data lands next frame.
      if (bus.Load) begin
        sh_data   <= bus.Data;
        sh_dp     <= bus.DP;
        sh_blz    <= bus.Blank_LZ;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end

      if (!bus.EN) begin
        state_q <= IDLE;
        idx_q   <= '0;
        div_q   <= '0;
        dead_q  <= '0;
        com_q   <= COM_OFF;
        seg_q   <= SEG_OFF;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SCAN;
            idx_q   <= '0;
            div_q   <= '0;
            com_q   <= com_first;
            seg_q   <= seg_first;
          end
          SCAN: begin
            if (last_lit) begin
              div_q <= '0;
              if (DEAD_CYCLES == 0) begin
                idx_q <= idx_nx;
                com_q <= com_next;
                seg_q <= seg_next;
              end else begin
                state_q <= DEAD;
                dead_q  <= DEAD_LOAD;
                com_q   <= COM_OFF;
                seg_q   <= SEG_OFF;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          DEAD: begin
            if (dead_q == '0) begin
              state_q <= SCAN;
              idx_q   <= idx_nx;
              com_q   <= com_next;
              seg_q   <= seg_next;
            end else begin
              dead_q <= dead_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.COM        = com_q;
  assign bus.SEG        = seg_q;
  assign bus.Load_Ack   = load_ack_q;
  assign bus.Frame_Tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: frame-position reference model checked every
// cycle, a table of decode/blanking vectors, and directed corner sequences.
module tb_seg_scan_display;
  localparam int ND     = 4;
  localparam int DIV    = 10;
  localparam int DEADC  = 2;
  localparam int SLOT   = DIV + DEADC;
  localparam int PERIOD = ND * SLOT;
  localparam int BND    = (ND - 1) * SLOT + DIV;
  localparam int NV     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_display_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_display #(
    .NUM_DIGITS(ND), .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYCLES(DEADC),
    .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Sys_CLK(clk),
    .Sys_RST(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [6:0] hex_tab [16];

  // Model: position m_p counts cycles since display entry; slots are SLOT long.
  bit         m_run;
  int         m_p;
  logic [15:0] m_sh_d, m_act_d;
  logic [3:0]  m_sh_dp, m_act_dp;
  logic        m_sh_b, m_act_b, m_pend, m_ack, m_tick;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] segs;
  } vec_t;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [15:0] data, input logic [3:0] dp,
                                         input logic blz, input int d);
    logic [15:0] upper;
    logic [6:0]  a2g;
    upper = data >> (4 * d);
    a2g   = (blz && d > 0 && upper == 16'h0) ? 7'h00 : hex_tab[upper[3:0]];
    return ~{dp[d], a2g};
  endfunction

  task automatic model_reset();
    m_run = 0; m_p = 0;
    m_sh_d = '0; m_sh_dp = '0; m_sh_b = 1'b0;
    m_act_d = '0; m_act_dp = '0; m_act_b = 1'b0;
    m_pend = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_update();
    bit entry, frame, commit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    entry = 0; frame = 0;
    if (!bus.EN) m_run = 0;
    else if (!m_run) begin
      m_run = 1; m_p = 0; entry = 1;
    end else begin
      m_p++;
      frame = ((m_p % PERIOD) == BND);
    end
    commit = (entry || frame) && m_pend;
    m_ack  = commit;
    m_tick = frame;
    if (commit) begin
      m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_b = m_sh_b;
    end
    if (bus.Load) begin
      m_sh_d = bus.Data; m_sh_dp = bus.DP; m_sh_b = bus.Blank_LZ; m_pend = 1'b1;
    end else if (commit) m_pend = 1'b0;
  endtask

  task automatic step();
    logic [3:0] ecom;
    logic [7:0] eseg;
    int d;
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    ecom = 4'hF;
    eseg = 8'hFF;
    if (m_run && (m_p % SLOT) < DIV) begin
      d    = (m_p / SLOT) % ND;
      ecom = ~(4'b0001 << d);
      eseg = ref_seg(m_act_d, m_act_dp, m_act_b, d);
    end
    chk("com", bus.COM, ecom);
    chk("seg", bus.SEG, eseg);
    chk("load_ack", bus.Load_Ack, m_ack);
    chk("frame_tick", bus.Frame_Tick, m_tick);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
    bus.Data = d; bus.DP = p; bus.Blank_LZ = b; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
  endtask

  task automatic wait_com(input logic [3:0] want, input int limit, output bit found);
    found = 0;
    for (int k = 0; k < limit && !found; k++) begin
      step();
      if (bus.COM === want) found = 1;
    end
  endtask

  task automatic wait_ack(input int limit, output bit found);
    found = 0;
    for (int k = 0; k < limit && !found; k++) begin
      step();
      if (bus.Load_Ack === 1'b1) found = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int t1, t2, a1, a2;
    logic [3:0] want_com;

    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h12AF, 4'b0010, 1'b0, 32'hF9A4_088E};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, 32'hFFFF_F8C0};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFF_FFC0};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0_C0C0};
    vecs[4] = '{16'h0905, 4'b0100, 1'b1, 32'hFF10_C092};
    vecs[5] = '{16'h0000, 4'b1001, 1'b1, 32'h7FFF_FF40};
    vecs[6] = '{16'hBCDE, 4'b0000, 1'b0, 32'h83C6_A186};
    vecs[7] = '{16'h3456, 4'b0000, 1'b1, 32'hB099_9282};

    bus.EN = 1'b0; bus.Load = 1'b0; bus.Data = '0; bus.DP = '0; bus.Blank_LZ = 1'b0;
    model_reset();

    #22;
    chk("rst_com", bus.COM, 4'hF);
    chk("rst_seg", bus.SEG, 8'hFF);
    chk("rst_ack", bus.Load_Ack, 1'b0);
    chk("rst_tick", bus.Frame_Tick, 1'b0);

    @(negedge clk);
    rst_n  = 1'b1;
    bus.EN = 1'b1;

    // Free-running scan with reset data: frame ticks 48 cycles apart.
    t1 = -1; t2 = -1;
    for (int k = 0; k < 150 && t2 < 0; k++) begin
      step();
      if (bus.Frame_Tick === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    chk("first_tick_cycle", t1, 47);
    chk("tick_period", t2 - t1, 48);

    // Decode and blanking table.
    for (int v = 0; v < NV; v++) begin
      do_load(vecs[v].data, vecs[v].dp, vecs[v].blz);
      wait_ack(120, found);
      chk("vec_ack_seen", found, 1'b1);
      chk("vec_ack_with_tick", bus.Frame_Tick, 1'b1);
      for (int d = 0; d < ND; d++) begin
        want_com = ~(4'b0001 << d);
        wait_com(want_com, 60, found);
        chk("vec_digit_seen", found, 1'b1);
        chk("vec_seg", bus.SEG, vecs[v].segs[8*d +: 8]);
      end
    end

    // Load on the boundary cycle: previous shadow commits, new data one frame later.
    do_load(16'h0001, 4'b0000, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_run && ((m_p + 1) % PERIOD) == BND) found = 1;
      else step();
    end
    chk("bnd_reach", found, 1'b1);
    do_load(16'h0002, 4'b0000, 1'b0);
    chk("bnd_ack1", bus.Load_Ack, 1'b1);
    chk("bnd_tick1", bus.Frame_Tick, 1'b1);
    a1 = cyc;
    wait_com(4'hE, 60, found);
    chk("bnd_old_seen", found, 1'b1);
    chk("bnd_old_seg", bus.SEG, 8'hF9);
    wait_ack(100, found);
    chk("bnd_ack2_seen", found, 1'b1);
    a2 = cyc;
    chk("bnd_ack_spacing", a2 - a1, 48);
    wait_com(4'hE, 60, found);
    chk("bnd_new_seen", found, 1'b1);
    chk("bnd_new_seg", bus.SEG, 8'hA4);

    // EN drop during digit 2 lit time with a pending load.
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_run && (m_p % SLOT) < 5 && ((m_p / SLOT) % ND) == 2) found = 1;
      else step();
    end
    chk("en_digit2_reach", found, 1'b1);
    do_load(16'h0400, 4'b0000, 1'b1);
    bus.EN = 1'b0;
    step();
    chk("en_off_com", bus.COM, 4'hF);
    chk("en_off_seg", bus.SEG, 8'hFF);
    chk("en_off_tick", bus.Frame_Tick, 1'b0);
    repeat (3) step();
    bus.EN = 1'b1;
    step();
    chk("en_on_com", bus.COM, 4'hE);
    chk("en_on_seg", bus.SEG, 8'hC0);
    chk("en_on_ack", bus.Load_Ack, 1'b1);

    // Asynchronous reset during dead time.
    do_load(16'h0007, 4'b0001, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_run && (m_p % SLOT) >= DIV) found = 1;
      else step();
    end
    chk("dead_reach", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_com", bus.COM, 4'hF);
    chk("async_rst_seg", bus.SEG, 8'hFF);
    chk("async_rst_ack", bus.Load_Ack, 1'b0);
    chk("async_rst_tick", bus.Frame_Tick, 1'b0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_com", bus.COM, 4'hE);
    chk("post_rst_seg", bus.SEG, 8'hC0);
    repeat (60) step();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if (bus.EN) begin
        if ($urandom_range(0, 99) < 1) bus.EN = 1'b0;
      end else if ($urandom_range(0, 99) < 30) bus.EN = 1'b1;
      if ($urandom_range(0, 99) < 4) begin
        bus.Load = 1'b1;
        case ($urandom_range(0, 4))
          0: bus.Data = 16'($urandom) & 16'hFFFF;
          1: bus.Data = 16'($urandom) & 16'h0FFF;
          2: bus.Data = 16'($urandom) & 16'h00FF;
          3: bus.Data = 16'($urandom) & 16'h000F;
          default: bus.Data = 16'h0000;
        endcase
        bus.DP       = 4'($urandom);
        bus.Blank_LZ = 1'($urandom);
      end else begin
        bus.Load = 1'b0;
      end
      step();
    end
    bus.Load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
